// File: rtl/seq_expander.sv
// Sequence expander: turns (literal length, match length, offset) lanes plus a literal
// byte stream into the reconstructed byte stream, copying matches out of a history window.
`ifndef SEQ_PACKET_SIZE
`define SEQ_PACKET_SIZE 4
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 8
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 8
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module seq_expander #(
  parameter int SEQ_PACKET_SIZE = `SEQ_PACKET_SIZE,
  parameter int SEQ_LL_BITS     = `SEQ_LL_BITS,
  parameter int SEQ_ML_BITS     = `SEQ_ML_BITS,
  parameter int SEQ_OFFSET_BITS = `SEQ_OFFSET_BITS,
  parameter int WINDOW_LOG      = 12
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_seq_packet_valid,
  output logic                                   i_seq_packet_ready,
  input  logic [SEQ_PACKET_SIZE-1:0]             i_seq_packet_strb,
  input  logic [SEQ_PACKET_SIZE*SEQ_LL_BITS-1:0] i_seq_packet_ll,
  input  logic [SEQ_PACKET_SIZE*SEQ_ML_BITS-1:0] i_seq_packet_ml,
  input  logic [SEQ_PACKET_SIZE*SEQ_OFFSET_BITS-1:0] i_seq_packet_offset,
  input  logic [SEQ_PACKET_SIZE*SEQ_ML_BITS-1:0] i_seq_packet_overlap,
  input  logic [SEQ_PACKET_SIZE-1:0]             i_seq_packet_eoj,
  input  logic [SEQ_PACKET_SIZE-1:0]             i_seq_packet_delim,
  input  logic                                   i_lit_valid,
  output logic                                   i_lit_ready,
  input  logic [7:0]                             i_lit_data,
  output logic                                   o_valid,
  input  logic                                   o_ready,
  output logic [7:0]                             o_data,
  output logic                                   o_delim,
  output logic                                   o_eoj,
  output logic                                   o_err,
  output logic [2:0]                             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload never change while waiting for ready.

  localparam int DEPTH = 1 << WINDOW_LOG;
  localparam int HC_W  = WINDOW_LOG + 1;
  localparam int CMP_W = (SEQ_OFFSET_BITS > HC_W) ? SEQ_OFFSET_BITS : HC_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    LIT       = 3'd2,
    MATCH     = 3'd3,
    DONE_LANE = 3'd4
  } state_t;

  state_t state;

  // Packet register
  logic [SEQ_PACKET_SIZE-1:0]                 rem_q;
  logic [SEQ_PACKET_SIZE*SEQ_LL_BITS-1:0]     pkt_ll;
  logic [SEQ_PACKET_SIZE*SEQ_ML_BITS-1:0]     pkt_ml;
  logic [SEQ_PACKET_SIZE*SEQ_OFFSET_BITS-1:0] pkt_off;
  logic [SEQ_PACKET_SIZE-1:0]                 pkt_eoj;
  logic [SEQ_PACKET_SIZE-1:0]                 pkt_delim;

  // Current lane
  logic [SEQ_LL_BITS-1:0]     ll_cnt;
  logic [SEQ_ML_BITS-1:0]     ml_cnt;
  logic [SEQ_OFFSET_BITS-1:0] offset_q;
  logic                       cur_eoj;
  logic                       cur_delim;

  logic                  live_q;
  logic [WINDOW_LOG-1:0] wr_ptr;
  logic [HC_W-1:0]       hist_cnt;
  logic [7:0]            hist_mem [DEPTH];

  logic                       out_free;
  logic                       lit_fire;
  logic                       match_fire;
  logic                       load;
  logic                       load_last;
  logic [7:0]                 load_data;
  logic [WINDOW_LOG-1:0]      rd_addr;
  logic [SEQ_LL_BITS-1:0]     sel_ll;
  logic [SEQ_ML_BITS-1:0]     sel_ml;
  logic [SEQ_OFFSET_BITS-1:0] sel_off;
  logic                       sel_eoj;
  logic                       sel_delim;
  logic                       sel_err;

  // The overlap hint is redundant with offset/ml and carries no extra information here.
  wire unused_ok = ^i_seq_packet_overlap;

  assign dbg_state          = state;
  assign out_free           = ~o_valid | o_ready;
  assign i_seq_packet_ready = live_q & (state == IDLE);
  assign i_lit_ready        = (state == LIT) & out_free;
  assign lit_fire           = i_lit_ready & i_lit_valid;
  assign match_fire         = (state == MATCH) & out_free;
  assign load               = lit_fire | match_fire;
  assign rd_addr            = wr_ptr - WINDOW_LOG'(offset_q);
  assign load_data          = lit_fire ? i_lit_data : hist_mem[rd_addr];
  assign load_last          = lit_fire ? ((ll_cnt == SEQ_LL_BITS'(1)) && (ml_cnt == '0))
                                       : (ml_cnt == SEQ_ML_BITS'(1));

  // Lowest-indexed lane still pending in the packet.
  always_comb begin
    sel_ll    = '0;
    sel_ml    = '0;
    sel_off   = '0;
    sel_eoj   = 1'b0;
    sel_delim = 1'b0;
    for (int i = SEQ_PACKET_SIZE - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        sel_ll    = pkt_ll[i*SEQ_LL_BITS +: SEQ_LL_BITS];
        sel_ml    = pkt_ml[i*SEQ_ML_BITS +: SEQ_ML_BITS];
        sel_off   = pkt_off[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS];
        sel_eoj   = pkt_eoj[i];
        sel_delim = pkt_delim[i];
      end
    end
  end

  assign sel_err = (sel_ml != '0) &&
                   ((sel_off == '0) || (CMP_W'(sel_off) > CMP_W'(hist_cnt)));

  // History contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load) begin
      hist_mem[wr_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      live_q    <= 1'b0;
      rem_q     <= '0;
      pkt_ll    <= '0;
      pkt_ml    <= '0;
      pkt_off   <= '0;
      pkt_eoj   <= '0;
      pkt_delim <= '0;
      ll_cnt    <= '0;
      ml_cnt    <= '0;
      offset_q  <= '0;
      cur_eoj   <= 1'b0;
      cur_delim <= 1'b0;
      wr_ptr    <= '0;
      hist_cnt  <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_delim   <= 1'b0;
      o_eoj     <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      live_q <= 1'b1;

      if (load) begin
        o_valid <= 1'b1;
        o_data  <= load_data;
        o_delim <= load_last & cur_delim;
        o_eoj   <= load_last & cur_eoj;
        wr_ptr  <= wr_ptr + WINDOW_LOG'(1);
        if (load_last && cur_eoj) begin
          hist_cnt <= '0;
        end else if (hist_cnt != HC_W'(DEPTH)) begin
          hist_cnt <= hist_cnt + HC_W'(1);
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (i_seq_packet_valid && i_seq_packet_ready) begin
            rem_q     <= i_seq_packet_strb;
            pkt_ll    <= i_seq_packet_ll;
            pkt_ml    <= i_seq_packet_ml;
            pkt_off   <= i_seq_packet_offset;
            pkt_eoj   <= i_seq_packet_eoj;
            pkt_delim <= i_seq_packet_delim;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (rem_q == '0) begin
            state <= IDLE;
          end else begin
            rem_q     <= rem_q & (rem_q - SEQ_PACKET_SIZE'(1));
            ll_cnt    <= sel_ll;
            ml_cnt    <= sel_ml;
            offset_q  <= sel_off;
            cur_eoj   <= sel_eoj;
            cur_delim <= sel_delim;
            if (sel_err) begin
              o_err <= 1'b1;
            end
            if (sel_ll != '0) begin
              state <= LIT;
            end else if (sel_ml != '0) begin
              state <= MATCH;
            end else begin
              state <= DONE_LANE;
            end
          end
        end
        LIT: begin
          if (lit_fire) begin
            ll_cnt <= ll_cnt - SEQ_LL_BITS'(1);
            if (ll_cnt == SEQ_LL_BITS'(1)) begin
              state <= (ml_cnt != '0) ? MATCH : DONE_LANE;
            end
          end
        end
        MATCH: begin
          if (match_fire) begin
            ml_cnt <= ml_cnt - SEQ_ML_BITS'(1);
            if (ml_cnt == SEQ_ML_BITS'(1)) begin
              state <= DONE_LANE;
            end
          end
        end
        DONE_LANE: begin
          state <= (rem_q != '0) ? SELECT : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_expander.sv
// Bench for seq_expander: directed lanes plus randomized packets, checked against a
// byte-level reference model of the reconstructed stream.
module tb_seq_expander;

  localparam int PS    = 4;
  localparam int LLB   = 8;
  localparam int MLB   = 8;
  localparam int OFFB  = 16;
  localparam int WL    = 12;
  localparam int DEPTH = 1 << WL;

  logic              clk;
  logic              rst_n;
  logic              i_seq_packet_valid;
  logic              i_seq_packet_ready;
  logic [PS-1:0]     p_strb;
  logic [PS*LLB-1:0] p_ll;
  logic [PS*MLB-1:0] p_ml;
  logic [PS*OFFB-1:0] p_off;
  logic [PS*MLB-1:0] p_ovl;
  logic [PS-1:0]     p_eoj;
  logic [PS-1:0]     p_delim;
  logic              i_lit_valid;
  logic              i_lit_ready;
  logic [7:0]        i_lit_data;
  logic              o_valid;
  logic              o_ready;
  logic [7:0]        o_data;
  logic              o_delim;
  logic              o_eoj;
  logic              o_err;
  logic [2:0]        dbg_state;

  seq_expander #(
    .SEQ_PACKET_SIZE(PS), .SEQ_LL_BITS(LLB), .SEQ_ML_BITS(MLB),
    .SEQ_OFFSET_BITS(OFFB), .WINDOW_LOG(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_seq_packet_valid(i_seq_packet_valid), .i_seq_packet_ready(i_seq_packet_ready),
    .i_seq_packet_strb(p_strb), .i_seq_packet_ll(p_ll), .i_seq_packet_ml(p_ml),
    .i_seq_packet_offset(p_off), .i_seq_packet_overlap(p_ovl),
    .i_seq_packet_eoj(p_eoj), .i_seq_packet_delim(p_delim),
    .i_lit_valid(i_lit_valid), .i_lit_ready(i_lit_ready), .i_lit_data(i_lit_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_delim(o_delim), .o_eoj(o_eoj), .o_err(o_err), .dbg_state(dbg_state)
  );

  // Clock and cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Scoreboard: {check_data, delim, eoj, data}
  logic [10:0] exp_q[$];
  logic [7:0]  lit_q[$];
  logic [7:0]  lit_src[$];
  int          t_q[$];
  int          out_cnt = 0;
  bit          rdy_mode = 0;
  bit          lit_mode = 0;
  bit          stall = 0;

  // Reference model state
  logic [7:0] mdl_mem [DEPTH];
  int         wp;
  int         job_cnt;
  bit         exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    wp = 0;
    job_cnt = 0;
    exp_err = 0;
  endtask

  task automatic model_emit(input logic [7:0] b, input bit care, input bit last,
                            input bit eoj, input bit delim);
    exp_q.push_back({care, last & delim, last & eoj, b});
    mdl_mem[wp % DEPTH] = b;
    wp++;
    if (last && eoj) job_cnt = 0;
    else if (job_cnt < DEPTH) job_cnt++;
  endtask

  task automatic clear_pkt();
    p_strb  = '0;
    p_ll    = $urandom();
    p_ml    = $urandom();
    p_off   = {$urandom(), $urandom()};
    p_ovl   = $urandom();
    p_eoj   = 4'($urandom());
    p_delim = 4'($urandom());
  endtask

  // Fills one lane of the pending packet and appends its bytes to the model stream.
  task automatic add_lane(input int idx, input int ll, input int ml, input int off,
                          input bit eoj, input bit delim);
    logic [7:0] b;
    bit care;
    p_strb[idx] = 1'b1;
    p_ll[idx*LLB +: LLB]    = LLB'(ll);
    p_ml[idx*MLB +: MLB]    = MLB'(ml);
    p_off[idx*OFFB +: OFFB] = OFFB'(off);
    p_eoj[idx]   = eoj;
    p_delim[idx] = delim;
    if (ml > 0 && (off == 0 || off > job_cnt)) exp_err = 1;
    for (int k = 0; k < ll; k++) begin
      b = (lit_src.size() > 0) ? lit_src.pop_front() : 8'($urandom());
      lit_q.push_back(b);
      model_emit(b, 1'b1, (k == ll - 1) && (ml == 0), eoj, delim);
    end
    for (int k = 0; k < ml; k++) begin
      care = (off != 0) && (off <= wp);
      b = care ? mdl_mem[(wp - off) % DEPTH] : 8'h00;
      model_emit(b, care, k == ml - 1, eoj, delim);
    end
  endtask

  task automatic send_packet();
    int n;
    @(negedge clk);
    i_seq_packet_valid = 1'b1;
    n = 0;
    while (!i_seq_packet_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("pkt_accept", {31'd0, i_seq_packet_ready}, 32'd1);
    @(posedge clk);
    #1 i_seq_packet_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && lit_q.size() == 0 && i_seq_packet_ready === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk(tag, {31'd0, n < 3000}, 32'd1);
    chk({tag, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out", {31'd0, n < 500}, 32'd1);
  endtask

  // Driver for literal stream and output sink; checks each byte accepted at the next edge.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [9:0]  got;
    o_ready = stall ? 1'b0 : (rdy_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (lit_q.size() > 0) begin
      i_lit_valid = lit_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_lit_data  = lit_q[0];
    end else begin
      i_lit_valid = 1'b0;
      i_lit_data  = 8'($urandom());
    end
    #1;
    if (rst_n) begin
      if (i_lit_valid && i_lit_ready) void'(lit_q.pop_front());
      if (o_valid && o_ready) begin
        cmp_cnt++;
        assert (exp_q.size() > 0) else begin
          err_cnt++;
          $error("FAIL extra_byte got=%0h exp=none", o_data);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          got = {o_delim, o_eoj, (e[10] ? o_data : e[7:0])};
          cmp_cnt++;
          assert (got === e[9:0]) else begin
            err_cnt++;
            $error("FAIL out_byte got=%0h exp=%0h", got, e[9:0]);
          end
        end
        out_cnt++;
        t_q.push_back(cyc);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ll, ml, off, lim;
    logic [7:0] held;

    rst_n = 1'b0;
    i_seq_packet_valid = 1'b0;
    clear_pkt();
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_data", {24'd0, o_data}, 32'd0);
    chk("rst_o_flags", {30'd0, o_delim, o_eoj}, 32'd0);
    chk("rst_o_err", {31'd0, o_err}, 32'd0);
    chk("rst_pkt_ready", {31'd0, i_seq_packet_ready}, 32'd0);
    chk("rst_lit_ready", {31'd0, i_lit_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel_pkt_ready", {31'd0, i_seq_packet_ready}, 32'd1);

    // Four literals, eoj on the last, back to back
    clear_pkt();
    lit_src = '{8'h61, 8'h62, 8'h63, 8'h64};
    add_lane(0, 4, 0, 0, 1, 0);
    t_q.delete();
    send_packet();
    wait_idle("t1_idle");
    chk("t1_count", t_q.size(), 32'd4);
    if (t_q.size() == 4) chk("t1_span", t_q[3] - t_q[0], 32'd3);

    // Offset-1 run after a literal, no bubbles
    clear_pkt();
    lit_src = '{8'h70, 8'h71};
    add_lane(0, 2, 0, 0, 0, 0);
    lit_src = '{8'h78};
    add_lane(1, 1, 5, 1, 0, 0);
    t_q.delete();
    send_packet();
    wait_idle("t2_idle");
    chk("t2_count", t_q.size(), 32'd8);
    if (t_q.size() == 8) chk("t2_span", t_q[7] - t_q[2], 32'd5);

    // Sparse strobe, repeat of three with delim at the end
    clear_pkt();
    lit_src = '{8'h61, 8'h62, 8'h63};
    add_lane(0, 3, 0, 0, 0, 0);
    add_lane(2, 0, 3, 3, 0, 1);
    send_packet();
    wait_idle("t3_idle");

    // Output stall inside a match
    clear_pkt();
    lit_src = '{8'h6b};
    add_lane(0, 1, 12, 1, 0, 0);
    add_lane(1, 2, 0, 0, 0, 0);
    base = out_cnt;
    send_packet();
    wait_out(base + 3);
    #2 stall = 1'b1;
    @(negedge clk);
    #2 held = o_data;
    chk("stall_valid0", {31'd0, o_valid}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_data", {24'd0, o_data}, {24'd0, held});
      chk("stall_lit_ready", {31'd0, i_lit_ready}, 32'd0);
    end
    stall = 1'b0;
    wait_idle("t4_idle");

    // Empty packet yields no bytes
    clear_pkt();
    send_packet();
    wait_idle("t5_idle");

    // Random packets with random back-pressure on both streams
    rdy_mode = 1'b1;
    lit_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      clear_pkt();
      for (int i = 0; i < PS; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          ll = $urandom_range(0, 5);
          ml = $urandom_range(0, 6);
          if (job_cnt == 0) ml = 0;
          lim = ($urandom_range(0, 1) == 0 && job_cnt > 8) ? 8 : job_cnt;
          off = (ml > 0) ? $urandom_range(1, lim) : $urandom_range(0, 100);
          add_lane(i, ll, ml, off, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        end
      end
      send_packet();
    end
    wait_idle("rand_idle");

    // Offset past the start of the job raises a sticky error
    rdy_mode = 1'b0;
    lit_mode = 1'b0;
    clear_pkt();
    add_lane(0, 1, 0, 0, 1, 0);
    add_lane(1, 0, 2, 7, 0, 0);
    send_packet();
    wait_idle("t6_idle");
    chk("t6_err", {31'd0, o_err}, 32'd1);
    repeat (10) @(negedge clk);
    #2 chk("t6_err_sticky", {31'd0, o_err}, 32'd1);

    // Reset in the middle of a literal run
    lit_mode = 1'b1;
    clear_pkt();
    add_lane(0, 10, 0, 0, 0, 0);
    base = out_cnt;
    send_packet();
    wait_out(base + 3);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_o_err", {31'd0, o_err}, 32'd0);
    chk("mid_rst_lit_ready", {31'd0, i_lit_ready}, 32'd0);
    exp_q.delete();
    lit_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #3 chk("mid_rst_pkt_ready", {31'd0, i_seq_packet_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("mid_rel_pkt_ready", {31'd0, i_seq_packet_ready}, 32'd1);

    // Normal traffic after reset
    rdy_mode = 1'b1;
    clear_pkt();
    add_lane(0, 3, 0, 0, 0, 0);
    add_lane(3, 2, 4, 2, 1, 1);
    send_packet();
    wait_idle("t7_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seq_expander.md
SEQ_EXPANDER -- requirements
Module: seq_expander

Interface
REQ-001 SHALL have parameters: SEQ_PACKET_SIZE, default `SEQ_PACKET_SIZE, lanes per packet; SEQ_LL_BITS, default `SEQ_LL_BITS, literal-length width; SEQ_ML_BITS, default `SEQ_ML_BITS, match-length width; SEQ_OFFSET_BITS, default `SEQ_OFFSET_BITS, offset width; WINDOW_LOG, default 12, log2 of history bytes.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_seq_packet_valid  in  1  packet valid
- i_seq_packet_ready  out  1  packet accepted when valid&ready
- i_seq_packet_strb  in  SEQ_PACKET_SIZE  lane present
- i_seq_packet_ll  in  SEQ_PACKET_SIZE*SEQ_LL_BITS  literal length per lane
- i_seq_packet_ml  in  SEQ_PACKET_SIZE*SEQ_ML_BITS  match length per lane
- i_seq_packet_offset  in  SEQ_PACKET_SIZE*SEQ_OFFSET_BITS  match distance per lane
- i_seq_packet_overlap  in  SEQ_PACKET_SIZE*SEQ_ML_BITS  informational, ignored
- i_seq_packet_eoj  in  SEQ_PACKET_SIZE  lane ends job
- i_seq_packet_delim  in  SEQ_PACKET_SIZE  lane ends input block
- i_lit_valid / i_lit_ready  in / out  1 / 1  literal byte handshake
- i_lit_data  in  8  literal byte
- o_valid / o_ready  out / in  1 / 1  output byte handshake
- o_data  out  8  reconstructed byte
- o_delim  out  1  last byte of a delim lane
- o_eoj  out  1  last byte of an eoj lane
- o_err  out  1  sticky offset error

Function
REQ-003 SHALL assert i_seq_packet_ready only in state IDLE; acceptance latches all packet fields into a packet register and moves to SELECT.
REQ-004 SHALL process strobed lanes in ascending lane index; lanes with strb=0 skipped; all-zero strb packet returns to IDLE after one SELECT cycle with no output.
REQ-005 States: IDLE, SELECT (load lane counters ll_cnt, ml_cnt, offset), LIT (ll_cnt>0), MATCH (ml_cnt>0), DONE_LANE; SELECT->LIT if ll>0, else MATCH if ml>0, else DONE_LANE; LIT->MATCH when ll_cnt reaches 0 and ml>0, else DONE_LANE; MATCH->DONE_LANE when ml_cnt reaches 0; DONE_LANE->SELECT if strobed lanes remain, else IDLE.
REQ-006 LIT: one byte per cycle when i_lit_valid and output register free (~o_valid|o_ready); i_lit_ready asserted only in LIT with output register free; byte moves to o_data, ll_cnt decrements.
REQ-007 MATCH: one byte per cycle when output register free; byte = history[wr_ptr-offset] (mod 2^WINDOW_LOG), combinational read; ml_cnt decrements.
REQ-008 History: 2^WINDOW_LOG-byte circular buffer; every byte loaded into the output register written at wr_ptr same cycle, wr_ptr increments and wraps; offset<ml (overlapping copy) SHALL reproduce bytes written in previous cycles (offset=1 repeats last byte).
REQ-009 Output register: o_valid/o_data/o_delim/o_eoj hold stable while o_valid&~o_ready; latency LIT byte i_lit accept edge N -> o_valid visible after edge N.
REQ-010 o_delim/o_eoj SHALL be set only on the final byte of the lane carrying the flag (last match byte, or last literal if ml=0); lane with ll=0,ml=0 and flags set emits no byte and the flags are dropped.
REQ-011 hist_cnt: bytes emitted in current job, saturating at 2^WINDOW_LOG; cleared after the o_eoj byte is loaded.
REQ-012 o_err SHALL set (sticky until reset) at SELECT of a lane with ml>0 and (offset=0 or offset>hist_cnt); the match is still emitted from the buffer.
REQ-013 Throughput: 1 byte/cycle within a lane; SELECT and DONE_LANE each cost one cycle; packet accept costs one cycle.

Reset
REQ-014 rst_n low SHALL asynchronously force state IDLE, i_seq_packet_ready=0 during reset, i_lit_ready=0, o_valid=0, o_data=0, o_delim=0, o_eoj=0, o_err=0, wr_ptr=0, hist_cnt=0, counters 0; history contents undefined.
REQ-015 Reset mid-packet SHALL discard packet register and pending output byte; after release, i_seq_packet_ready=1 next cycle.

Verification
REQ-016 One lane ll=4, ml=0, eoj=1, literals 'a','b','c','d', o_ready=1 -> o_data a,b,c,d on 4 consecutive cycles, o_eoj only on 'd', o_err=0.
REQ-017 Lane ll=1 ('x'), ml=5, offset=1 -> output x,x,x,x,x,x (6 bytes), no bubbles.
REQ-018 Lanes 0 and 2 strobed: lane0 ll=3 "abc" ml=0; lane2 ll=0 ml=3 offset=3 delim=1 -> a,b,c,a,b,c; o_delim on final 'c'.
REQ-019 o_ready held low 5 cycles during MATCH -> o_data/o_valid stable, ml_cnt unchanged, no literal consumed; resumes exactly once per byte.
REQ-020 First lane of job ml=2 offset=7 with hist_cnt=0 -> o_err=1 and stays 1 until rst_n low; rst_n asserted mid-LIT -> o_valid=0 immediately, IDLE after release.
